stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

BCD stopwatch stage fed by the 1 kHz divider. It runs on the 1 MHz system clock and treats the divider's 1 kHz square wave as a millisecond time base, detecting its rising edges. It counts elapsed time as SS.cc (seconds and centiseconds, 00.00 to 59.99) under start/stop and clear control. Its BCD output feeds the 7-segment display scanner.

## Interface
- TICKS_PER_CS, default 10: 1 kHz rising edges per centisecond. Legal range is 1..15; a bench override of 1 is allowed.
- clk  in  1  system clock, 1 MHz.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- i_tick  in  1  1 kHz square wave from the divider, synchronous to clk.
- i_start_stop  in  1  single-cycle pulse that toggles run/pause.
- i_clear  in  1  single-cycle pulse that stops the stopwatch and zeroes the count.
- o_bcd  out  16  {s_tens[15:12], s_ones[11:8], cs_tens[7:4], cs_ones[3:0]}.
- o_running  out  1  high while in RUN.
- o_wrap  out  1  one-cycle pulse when the count rolls over from 59.99 to 00.00.

## Operation
- Edge detect: register tick_d <= i_tick every cycle.
  - tick_rise = i_tick & ~tick_d.
  - tick_d resets to 1, so an i_tick that is high when reset releases is not counted.
- States (2-bit register): IDLE, RUN, PAUSE.
  - IDLE: counters are zero and o_running = 0. i_start_stop goes to RUN.
  - RUN: o_running = 1. i_start_stop goes to PAUSE.
  - PAUSE: o_running = 0 and counters hold. i_start_stop goes to RUN.
  - i_clear in any state goes to IDLE and zeroes the digits and the prescaler. i_clear has priority over i_start_stop in the same cycle.
- Prescaler: a 4-bit counter, 0..TICKS_PER_CS-1, that advances only on tick_rise while the current state is RUN.
  - On tick_rise at TICKS_PER_CS-1 it returns to 0 and issues one centisecond increment.
  - It holds its value in PAUSE, so a partial centisecond is preserved across a pause.
- Digit cascade (each digit is a 4-bit BCD value and never leaves its range):
  - cs_ones 0..9; its carry advances cs_tens.
  - cs_tens 0..9; its carry advances s_ones.
  - s_ones 0..9; its carry advances s_tens.
  - s_tens 0..5.
- Rollover: an increment at 59.99 produces 00.00 and pulses o_wrap. The state stays RUN.
- A state-changing event is evaluated against the current state. When a tick_rise and i_start_stop occur together:
  - In RUN, the tick is counted and the next state is PAUSE.
  - In PAUSE, the tick is not counted and the next state is RUN.
- i_start_stop and i_clear are assumed to be already debounced single-cycle pulses; they are not edge-detected here.

## Timing
- All outputs are registered. Reset values:
  - o_bcd = 16'h0000, o_running = 0, o_wrap = 0.
  - state = IDLE, prescaler = 0, tick_d = 1.
- Count latency: on the clk edge that samples i_tick = 1 with tick_d = 0, the prescaler and digits update. o_bcd shows the new value in the following cycle; total latency is 1 clk from i_tick rising.
- o_running changes on the edge that samples i_start_stop or i_clear.
- o_wrap is high for exactly one clk cycle, the same cycle in which o_bcd first reads 0000 after 5999.
- Reset asserted mid-operation: on the next edge everything returns to its reset value. Any in-flight tick and any pending pulse are discarded.
- With the nominal 1 kHz input there is at most one tick_rise per 1000 clk cycles. The design must nevertheless handle a tick_rise on every other cycle (i_tick toggling every clk) without losing counts.

## Test plan
- Reset, then toggle i_tick for 50 periods with no start: o_bcd = 0x0000 and o_running = 0 throughout.
- Start with TICKS_PER_CS = 10, then apply 10 rises: o_bcd = 0x0001. Continue to 1000 rises total: o_bcd = 0x0100.
- Pause-preserves-prescaler case:
  - Start, apply 15 rises (0x0001), then pulse start_stop to pause.
  - Apply 20 rises: o_bcd is still 0x0001.
  - Resume and apply 5 rises: o_bcd = 0x0002.
- Rollover with TICKS_PER_CS = 1:
  - Start and apply 5999 rises: o_bcd = 0x5999.
  - The next rise gives 0x0000 with o_wrap high for 1 cycle. o_running stays 1, and 1 further rise gives 0x0001.
- In RUN at 0x0123, pulse i_clear and i_start_stop in the same cycle: state goes to IDLE, o_bcd = 0x0000, o_running = 0. A following start_stop resumes counting from 0.
- Reset-with-tick-high case:
  - Assert reset mid-run while i_tick is high, and release it with i_tick still high: o_bcd = 0x0000.
  - After start, no count occurs until i_tick goes 0 and then 1. The first centisecond appears after 10 such rises.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// SS.cc BCD stopwatch counting rising edges of a 1 kHz time base under start/stop and clear.
// Outputs are registered; the digit cascade rolls 59.99 -> 00.00 with a one-cycle wrap pulse.
module stopwatch_bcd #(
  parameter int TICKS_PER_CS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_tick,
  input  logic        i_start_stop,
  input  logic        i_clear,
  output logic [15:0] o_bcd,
  output logic        o_running,
  output logic        o_wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(TICKS_PER_CS - 1);

  state_t     state, state_next;
  logic       tick_d;
  logic       tick_rise;
  logic       cs_inc;
  logic [3:0] presc, presc_next;
  logic [3:0] s_tens, s_ones, cs_tens, cs_ones;
  logic [4:0] st0, st1, st2, st3;

  // Returns {carry, next digit}; wraps to 0 past top when enabled.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] top,
                                          input logic en);
    if (!en) return {1'b0, d};
    if (d == top) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  assign tick_rise = i_tick & ~tick_d;

  always_comb begin
    state_next = state;
    if (i_clear) begin
      state_next = IDLE;
    end else if (i_start_stop) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Ticks count against the current state, so a tick coinciding with a pause is still taken.
  always_comb begin
    presc_next = presc;
    cs_inc     = 1'b0;
    if (state == RUN && tick_rise) begin
      if (presc == LAST) begin
        presc_next = 4'd0;
        cs_inc     = 1'b1;
      end else begin
        presc_next = presc + 4'd1;
      end
    end
  end

  assign st0 = bcd_step(cs_ones, 4'd9, cs_inc);
  assign st1 = bcd_step(cs_tens, 4'd9, st0[4]);
  assign st2 = bcd_step(s_ones,  4'd9, st1[4]);
  assign st3 = bcd_step(s_tens,  4'd5, st2[4]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick_d    <= 1'b1;
      presc     <= 4'd0;
      cs_ones   <= 4'd0;
      cs_tens   <= 4'd0;
      s_ones    <= 4'd0;
      s_tens    <= 4'd0;
      o_running <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      state     <= state_next;
      tick_d    <= i_tick;
      o_running <= (state_next == RUN);
      if (i_clear) begin
        presc   <= 4'd0;
        cs_ones <= 4'd0;
        cs_tens <= 4'd0;
        s_ones  <= 4'd0;
        s_tens  <= 4'd0;
        o_wrap  <= 1'b0;
      end else begin
        presc   <= presc_next;
        cs_ones <= st0[3:0];
        cs_tens <= st1[3:0];
        s_ones  <= st2[3:0];
        s_tens  <= st3[3:0];
        o_wrap  <= st3[4];
      end
    end
  end

  assign o_bcd = {s_tens, s_ones, cs_tens, cs_ones};

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: two instances (10 and 1 ticks per centisecond) checked every cycle
// against an integer-centisecond model, plus literal expectations at key points.
module tb_stopwatch_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_tick = 1'b0;
  logic        i_start_stop = 1'b0;
  logic        i_clear = 1'b0;
  logic [15:0] bcd0, bcd1;
  logic        run0, run1, wrap0, wrap1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model state: elapsed centiseconds, partial ticks, mode 0=idle 1=run 2=pause.
  int m_cs[2];
  int m_pre[2];
  int m_mode[2];
  bit m_wrap[2];
  bit m_prev;
  int tpc[2];

  // Literal-check handshake to the compare process.
  int          lit_seq = 0;
  int          lit_done = 0;
  string       lit_name;
  int          lit_inst;
  logic [15:0] lit_bcd;
  logic        lit_run;
  logic        lit_wrap;

  always #5 clk = ~clk;

  stopwatch_bcd #(.TICKS_PER_CS(10)) u10 (
    .clk(clk), .reset(reset), .i_tick(i_tick), .i_start_stop(i_start_stop),
    .i_clear(i_clear), .o_bcd(bcd0), .o_running(run0), .o_wrap(wrap0)
  );

  stopwatch_bcd #(.TICKS_PER_CS(1)) u1 (
    .clk(clk), .reset(reset), .i_tick(i_tick), .i_start_stop(i_start_stop),
    .i_clear(i_clear), .o_bcd(bcd1), .o_running(run1), .o_wrap(wrap1)
  );

  function automatic logic [15:0] to_bcd(input int cs);
    logic [15:0] r;
    r[15:12] = 4'(cs / 1000);
    r[11:8]  = 4'((cs / 100) % 10);
    r[7:4]   = 4'((cs / 10) % 10);
    r[3:0]   = 4'(cs % 10);
    return r;
  endfunction

  initial begin
    bit rise;
    tpc[0] = 10;
    tpc[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_cs[k] = 0; m_pre[k] = 0; m_mode[k] = 0; m_wrap[k] = 0;
    end
    m_prev = 1'b1;
    forever begin
      @(posedge clk);
      rise = i_tick && !m_prev;
      for (int k = 0; k < 2; k++) begin
        m_wrap[k] = 0;
        if (reset || i_clear) begin
          m_cs[k] = 0; m_pre[k] = 0; m_mode[k] = 0;
        end else begin
          if (m_mode[k] == 1 && rise) begin
            m_pre[k]++;
            if (m_pre[k] == tpc[k]) begin
              m_pre[k] = 0;
              m_cs[k]++;
              if (m_cs[k] == 6000) begin
                m_cs[k] = 0;
                m_wrap[k] = 1;
              end
            end
          end
          if (i_start_stop) m_mode[k] = (m_mode[k] == 1) ? 2 : 1;
        end
      end
      m_prev = reset ? 1'b1 : i_tick;
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  initial begin
    logic [15:0] b;
    logic        r, w;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          b = (k == 0) ? bcd0 : bcd1;
          r = (k == 0) ? run0 : run1;
          w = (k == 0) ? wrap0 : wrap1;
          cmp($sformatf("cycle_bcd[%0d]", k), int'(b), int'(to_bcd(m_cs[k])));
          cmp($sformatf("cycle_running[%0d]", k), int'(r), (m_mode[k] == 1) ? 1 : 0);
          cmp($sformatf("cycle_wrap[%0d]", k), int'(w), int'(m_wrap[k]));
        end
      end
      if (lit_seq != lit_done) begin
        b = (lit_inst == 0) ? bcd0 : bcd1;
        r = (lit_inst == 0) ? run0 : run1;
        w = (lit_inst == 0) ? wrap0 : wrap1;
        cmp({lit_name, "_bcd"}, int'(b), int'(lit_bcd));
        cmp({lit_name, "_running"}, int'(r), int'(lit_run));
        cmp({lit_name, "_wrap"}, int'(w), int'(lit_wrap));
        lit_done = lit_seq;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int inst, input logic [15:0] eb,
                     input logic er, input logic ew);
    lit_name = name;
    lit_inst = inst;
    lit_bcd  = eb;
    lit_run  = er;
    lit_wrap = ew;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic rises(input int n);
    for (int i = 0; i < n; i++) begin
      i_tick = 1'b1; step();
      i_tick = 1'b0; step();
    end
  endtask

  task automatic pulse_ss();
    i_start_stop = 1'b1; step();
    i_start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1; step();
    i_clear = 1'b0;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    lit("reset_state", 0, 16'h0000, 1'b0, 1'b0);

    rises(50);
    lit("idle_ticks", 0, 16'h0000, 1'b0, 1'b0);

    pulse_ss();
    rises(10);
    lit("ten_rises", 0, 16'h0001, 1'b1, 1'b0);
    lit("ten_rises_tpc1", 1, 16'h0010, 1'b1, 1'b0);
    rises(990);
    lit("thousand_rises", 0, 16'h0100, 1'b1, 1'b0);
    lit("thousand_rises_tpc1", 1, 16'h1000, 1'b1, 1'b0);

    pulse_clear();
    pulse_ss();
    rises(15);
    lit("pause_before", 0, 16'h0001, 1'b1, 1'b0);
    pulse_ss();
    rises(20);
    lit("paused_hold", 0, 16'h0001, 1'b0, 1'b0);
    pulse_ss();
    rises(5);
    lit("resume_partial", 0, 16'h0002, 1'b1, 1'b0);
    lit("resume_tpc1", 1, 16'h0020, 1'b1, 1'b0);

    pulse_clear();
    pulse_ss();
    rises(5999);
    lit("pre_wrap", 1, 16'h5999, 1'b1, 1'b0);
    i_tick = 1'b1; step();
    lit("wrap_edge", 1, 16'h0000, 1'b1, 1'b1);
    i_tick = 1'b0; step();
    lit("wrap_done", 1, 16'h0000, 1'b1, 1'b0);
    rises(1);
    lit("after_wrap", 1, 16'h0001, 1'b1, 1'b0);
    lit("after_wrap_tpc10", 0, 16'h0600, 1'b1, 1'b0);

    pulse_clear();
    pulse_ss();
    rises(1230);
    lit("at_0123", 0, 16'h0123, 1'b1, 1'b0);
    i_clear = 1'b1; i_start_stop = 1'b1; step();
    i_clear = 1'b0; i_start_stop = 1'b0;
    lit("clear_beats_ss", 0, 16'h0000, 1'b0, 1'b0);
    pulse_ss();
    rises(10);
    lit("restart_from_zero", 0, 16'h0001, 1'b1, 1'b0);

    rises(3);
    i_tick = 1'b1; step();
    reset = 1'b1; step(); step();
    reset = 1'b0; step();
    lit("reset_tick_high", 0, 16'h0000, 1'b0, 1'b0);
    pulse_ss();
    step(); step();
    lit("no_count_tick_held", 0, 16'h0000, 1'b1, 1'b0);
    i_tick = 1'b0; step();
    rises(9);
    lit("nine_after_reset", 0, 16'h0000, 1'b1, 1'b0);
    rises(1);
    lit("ten_after_reset", 0, 16'h0001, 1'b1, 1'b0);
    lit("ten_after_reset_tpc1", 1, 16'h0010, 1'b1, 1'b0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
